// File: rtl/axis_test_pkg.sv
// rtl/axis_test_pkg.sv - shared types and constants for the AXIS test-pattern checker
// FSM encodings, error bit indices, tuser field slices and pattern helpers.
package axis_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BODY  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int ERR_DATA = 0;
   localparam int ERR_KEEP = 1;
   localparam int ERR_LEN  = 2;
   localparam int ERR_USER = 3;
   localparam int ERR_W    = 4;

   localparam int USER_W  = 80;
   localparam int LEN_HI  = 79;
   localparam int LEN_LO  = 64;
   localparam int MAC_HI  = 63;
   localparam int MAC_LO  = 16;
   localparam int TYPE_HI = 15;
   localparam int TYPE_LO = 0;

   // Generator fills every byte of beat n with n
   function automatic logic [63:0] beat_pattern(input logic [7:0] n);
      return {8{n}};
   endfunction

   function automatic logic [63:0] keep_mask(input logic [7:0] k);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) begin
         m[i*8 +: 8] = {8{k[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_keep_decode.sv
// rtl/axis_keep_decode.sv - tkeep byte popcount and last-beat legality decode
// Legal last-beat keeps are MSB-aligned contiguous runs, never empty.
module axis_keep_decode
   import axis_test_pkg::*;
(
   input  logic [7:0] tkeep,
   output logic [3:0] byte_cnt,
   output logic       last_legal
);

   always_comb begin
      byte_cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         byte_cnt = byte_cnt + {3'd0, tkeep[i]};
      end
   end

   always_comb begin
      last_legal = 1'b0;
      unique case (tkeep)
         8'hFF, 8'hFE, 8'hFC, 8'hF8,
         8'hF0, 8'hE0, 8'hC0, 8'h80: last_legal = 1'b1;
         default:                   last_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/axis_test_checker.sv
// rtl/axis_test_checker.sv - AXIS test-packet checker: pattern, keep, length and tuser checks
// AXIS_TEST_CHECKER_BACKPRESSURE_EN: LFSR-driven tready (~75% duty) instead of constant ready.
module axis_test_checker
   import axis_test_pkg::*;
#(
   parameter int          P_PKT_BEATS = 10,
   parameter logic [15:0] P_EXP_LEN   = 16'd10,
   parameter logic [47:0] P_EXP_MAC   = 48'h0102_0304_0506,
   parameter logic [15:0] P_EXP_TYPE  = 16'h0800,
   parameter int          P_PKT_NUM   = 10
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [63:0]        s_axis_tdata,
   input  logic [USER_W-1:0]  s_axis_tuser,
   input  logic [7:0]         s_axis_tkeep,
   input  logic               s_axis_tlast,
   input  logic               s_axis_tvalid,
   output logic               m_axis_tready,
   output logic [15:0]        o_pkt_cnt,
   output logic [15:0]        o_err_pkt_cnt,
   output logic [31:0]        o_byte_cnt,
   output logic [ERR_W-1:0]   o_err_type,
   output logic               o_done
);

   localparam logic [7:0]  LP_BEATS   = 8'(P_PKT_BEATS);
   localparam logic [15:0] LP_PKT_NUM = 16'(P_PKT_NUM);

   state_t            state;
   state_t            next_state;
   logic [7:0]        beat_idx;
   logic [7:0]        idx_next;
   logic [ERR_W-1:0]  pkt_err;
   logic [ERR_W-1:0]  beat_err;
   logic [ERR_W-1:0]  pkt_err_all;
   logic              rdy_q;
   logic              accept;
   logic              pkt_end;
   logic              data_err;
   logic              keep_err;
   logic              user_err;
   logic [3:0]        byte_pop;
   logic              last_legal;
   logic [15:0]       pkt_cnt_inc;
   logic [15:0]       err_cnt_inc;

   axis_keep_decode u_keep_decode (
      .tkeep      (s_axis_tkeep),
      .byte_cnt   (byte_pop),
      .last_legal (last_legal)
   );

`ifdef AXIS_TEST_CHECKER_BACKPRESSURE_EN
   logic [15:0] lfsr;

   // Fibonacci form of x^16+x^14+x^13+x^11+1
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign m_axis_tready = rdy_q & (lfsr[0] | lfsr[1]);
`else
   assign m_axis_tready = rdy_q;
`endif

   assign accept = s_axis_tvalid & m_axis_tready;

   assign idx_next = (state == ST_IDLE) ? 8'd1 : beat_idx + 8'd1;
   assign data_err = |((s_axis_tdata ^ beat_pattern(idx_next)) & keep_mask(s_axis_tkeep));
   assign keep_err = s_axis_tlast ? ~last_legal : (s_axis_tkeep != 8'hFF);
   assign user_err = (s_axis_tuser[LEN_HI:LEN_LO]   != P_EXP_LEN)  |
                     (s_axis_tuser[MAC_HI:MAC_LO]   != P_EXP_MAC)  |
                     (s_axis_tuser[TYPE_HI:TYPE_LO] != P_EXP_TYPE);

   always_comb begin
      beat_err   = '0;
      next_state = state;
      pkt_end    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            beat_err[ERR_DATA] = data_err;
            beat_err[ERR_KEEP] = keep_err;
            beat_err[ERR_USER] = user_err;
            if (s_axis_tlast) begin
               beat_err[ERR_LEN] = 1'b1;
               pkt_end           = 1'b1;
            end else begin
               next_state = ST_BODY;
            end
         end
         ST_BODY: begin
            beat_err[ERR_DATA] = data_err;
            beat_err[ERR_KEEP] = keep_err;
            if (s_axis_tlast) begin
               beat_err[ERR_LEN] = (idx_next != LP_BEATS);
               pkt_end           = 1'b1;
               next_state        = ST_IDLE;
            end else if (idx_next == LP_BEATS) begin
               beat_err[ERR_LEN] = 1'b1;
               next_state        = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (s_axis_tlast) begin
               pkt_end    = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign pkt_err_all = pkt_err | beat_err;
   assign pkt_cnt_inc = (o_pkt_cnt == 16'hFFFF) ? o_pkt_cnt : o_pkt_cnt + 16'd1;
   assign err_cnt_inc = (o_err_pkt_cnt == 16'hFFFF) ? o_err_pkt_cnt : o_err_pkt_cnt + 16'd1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= ST_IDLE;
         beat_idx      <= 8'd0;
         pkt_err       <= '0;
         rdy_q         <= 1'b0;
         o_pkt_cnt     <= 16'd0;
         o_err_pkt_cnt <= 16'd0;
         o_byte_cnt    <= 32'd0;
         o_err_type    <= '0;
         o_done        <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (accept) begin
            state      <= next_state;
            o_byte_cnt <= o_byte_cnt + {28'd0, byte_pop};
            if (next_state == ST_IDLE) begin
               beat_idx <= 8'd0;
            end else if (state != ST_DRAIN) begin
               beat_idx <= idx_next;
            end
            if (pkt_end) begin
               o_pkt_cnt  <= pkt_cnt_inc;
               o_err_type <= o_err_type | pkt_err_all;
               pkt_err    <= '0;
               if (|pkt_err_all) begin
                  o_err_pkt_cnt <= err_cnt_inc;
               end
               if (pkt_cnt_inc == LP_PKT_NUM) begin
                  o_done <= 1'b1;
               end
            end else begin
               pkt_err <= pkt_err_all;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_test_checker.sv
// tb/tb_axis_test_checker.sv - self-checking bench for axis_test_checker
// Per-scenario expectation table plus a per-packet error scoreboard.
module tb_axis_test_checker;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [63:0] s_axis_tdata = '0;
   logic [79:0] s_axis_tuser = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        m_axis_tready;
   logic [15:0] o_pkt_cnt;
   logic [15:0] o_err_pkt_cnt;
   logic [31:0] o_byte_cnt;
   logic [3:0]  o_err_type;
   logic        o_done;

   localparam logic [47:0] MAC = 48'h0102_0304_0506;

   int checks = 0;
   int errors = 0;
   bit gap_en = 1'b0;
   logic [3:0] sb_q[$];
   logic [15:0] prev_pkt = '0;
   logic [15:0] prev_err = '0;

   typedef struct {
      int          scen;
      logic [15:0] pkt;
      logic [15:0] err_pkt;
      logic [3:0]  err_type;
      logic [31:0] bytes;
      logic        done;
   } vec_t;

   vec_t vecs[8];

   axis_test_checker dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .o_pkt_cnt     (o_pkt_cnt),
      .o_err_pkt_cnt (o_err_pkt_cnt),
      .o_byte_cnt    (o_byte_cnt),
      .o_err_type    (o_err_type),
      .o_done        (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: each completed packet pops the error bits it was sent with
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            prev_pkt = '0;
            prev_err = '0;
         end else if (o_pkt_cnt != prev_pkt) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_pkt", 64'(o_pkt_cnt), 64'(prev_pkt));
            end else begin
               e = sb_q.pop_front();
               check("sb_err_pkt_step", 64'(16'(o_err_pkt_cnt - prev_err)), 64'(e != 4'd0));
               check("sb_err_bits", 64'(o_err_type & e), 64'(e));
            end
            prev_pkt = o_pkt_cnt;
            prev_err = o_err_pkt_cnt;
         end
      end
   end

   // Caller is at a negedge; returns at a negedge with tvalid low
   task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [79:0] u);
      bit rdy;
      bit acc = 1'b0;
      if (gap_en && $urandom_range(0, 2) == 0) begin
         s_axis_tvalid = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge i_clk);
      end
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
      s_axis_tvalid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         rdy = m_axis_tready;
         @(posedge i_clk);
         if (rdy) begin
            acc = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
      if (!acc) begin
         errors++;
         $display("FAIL beat_accept_timeout actual=0 expected=1");
      end
      @(negedge i_clk);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input int nbeats, input logic [7:0] last_keep, input int bad_data,
                           input int bad_keep, input logic [15:0] utype, input logic [3:0] exp_err);
      logic [7:0]  nb;
      logic [63:0] d;
      logic [7:0]  k;
      logic [79:0] u;
      sb_q.push_back(exp_err);
      for (int n = 1; n <= nbeats; n++) begin
         nb = 8'(n);
         d  = {8{nb}};
         if (n == bad_data) d = d ^ 64'h1;
         k  = (n == nbeats) ? last_keep : ((n == bad_keep) ? 8'hFE : 8'hFF);
         u  = (n == 1) ? {16'd10, MAC, utype} : ~{16'd10, MAC, 16'h0800};
         drive_beat(d, k, (n == nbeats), u);
      end
   endtask

   task automatic apply_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      s_axis_tvalid = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge i_clk);
      check("reset_outputs", {o_pkt_cnt, o_err_pkt_cnt, o_err_type, o_done, 27'd0}, 64'd0);
      check("reset_byte_cnt", 64'(o_byte_cnt), 64'd0);
      check("reset_tready", 64'(m_axis_tready), 64'd0);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("tready_after_reset", 64'(m_axis_tready), 64'd1);
   endtask

   task automatic run_scen(input int s);
      logic [7:0] keeps[10];
      logic [7:0] nb;
      keeps = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'hFF, 8'hFF};
      case (s)
         0: begin
            for (int p = 0; p < 10; p++) begin
               send_pkt(10, keeps[p], 0, 0, 16'h0800, 4'h0);
               if (p == 8) begin
                  repeat (2) @(negedge i_clk);
                  check("done_before_last", 64'(o_done), 64'd0);
               end
            end
         end
         1: send_pkt(10, 8'hFF, 4, 0, 16'h0800, 4'b0001);
         2: begin
            send_pkt(7, 8'hFF, 0, 0, 16'h0800, 4'b0100);
            send_pkt(12, 8'hFF, 0, 0, 16'h0800, 4'b0100);
         end
         3: begin
            send_pkt(10, 8'h0F, 0, 0, 16'h0800, 4'b0010);
            send_pkt(10, 8'hFF, 0, 5, 16'h0800, 4'b0010);
         end
         4: send_pkt(10, 8'hFF, 0, 0, 16'h0806, 4'b1000);
         5: begin
            for (int n = 1; n <= 4; n++) begin
               nb = 8'(n);
               drive_beat({8{nb}}, 8'hFF, 1'b0, {16'd10, MAC, 16'h0800});
            end
            s_axis_tdata  = {8{8'h05}};
            s_axis_tvalid = 1'b1;
            i_rst         = 1'b1;
            @(negedge i_clk);
            check("midpkt_reset_bytes", 64'(o_byte_cnt), 64'd0);
            check("midpkt_reset_pkts", 64'(o_pkt_cnt), 64'd0);
            s_axis_tvalid = 1'b0;
            @(negedge i_clk);
            i_rst = 1'b0;
            @(negedge i_clk);
            send_pkt(10, 8'hFF, 0, 0, 16'h0800, 4'h0);
         end
         6: begin
            gap_en = 1'b1;
            for (int p = 0; p < 3; p++) send_pkt(10, 8'hFF, 0, 0, 16'h0800, 4'h0);
            gap_en = 1'b0;
         end
         default: begin
            send_pkt(1, 8'hFF, 0, 0, 16'h0800, 4'b0100);
            send_pkt(10, 8'hFF, 0, 0, 16'h0800, 4'h0);
         end
      endcase
   endtask

   initial begin
      vecs[0] = '{0, 16'd10, 16'd0, 4'b0000, 32'd772, 1'b1};
      vecs[1] = '{1, 16'd1,  16'd1, 4'b0001, 32'd80,  1'b0};
      vecs[2] = '{2, 16'd2,  16'd2, 4'b0100, 32'd152, 1'b0};
      vecs[3] = '{3, 16'd2,  16'd2, 4'b0010, 32'd155, 1'b0};
      vecs[4] = '{4, 16'd1,  16'd1, 4'b1000, 32'd80,  1'b0};
      vecs[5] = '{5, 16'd1,  16'd0, 4'b0000, 32'd80,  1'b0};
      vecs[6] = '{6, 16'd3,  16'd0, 4'b0000, 32'd240, 1'b0};
      vecs[7] = '{7, 16'd2,  16'd1, 4'b0100, 32'd88,  1'b0};

      for (int i = 0; i < 8; i++) begin
         apply_reset();
         run_scen(vecs[i].scen);
         repeat (4) @(negedge i_clk);
         check($sformatf("s%0d_pkt_cnt", i), 64'(o_pkt_cnt), 64'(vecs[i].pkt));
         check($sformatf("s%0d_err_pkt_cnt", i), 64'(o_err_pkt_cnt), 64'(vecs[i].err_pkt));
         check($sformatf("s%0d_err_type", i), 64'(o_err_type), 64'(vecs[i].err_type));
         check($sformatf("s%0d_byte_cnt", i), 64'(o_byte_cnt), 64'(vecs[i].bytes));
         check($sformatf("s%0d_done", i), 64'(o_done), 64'(vecs[i].done));
         check($sformatf("s%0d_sb_drained", i), 64'(sb_q.size()), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
